// File: rtl/motor_drive_ctrl_if.sv
// Command channel into the motor drive controller: direction, speed and run length
// under a valid/ready handshake; master drives commands, slave returns ready.
interface motor_drive_ctrl_if #(
  parameter int PWM_W = 8,
  parameter int DUR_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_dir;
  logic [PWM_W-1:0] cmd_speed;
  logic [DUR_W-1:0] cmd_dur;

  modport master (output cmd_valid, output cmd_dir, output cmd_speed, output cmd_dur,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_dir, input  cmd_speed, input  cmd_dur,
                  output cmd_ready);
endinterface

// File: rtl/motor_drive_ctrl.sv
// Two-motor H-bridge drive: PWM speed, coast gap on direction change, optional timed run with done pulse.
// Outputs registered, commands take effect right after the accept edge; cmd_ready drops only while coasting in DEAD.
module motor_drive_ctrl #(
  parameter int PWM_W       = 8,
  parameter int PWM_DIV     = 390,
  parameter int TICK_DIV    = 100000,
  parameter int DUR_W       = 16,
  parameter int DEAD_CYCLES = 100000
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  motor_drive_ctrl_if.slave cmd,
  output logic [3:0]        motor,
  output logic              busy,
  output logic              done
);
  localparam int PSC_W  = (PWM_DIV > 1)     ? $clog2(PWM_DIV)     : 1;
  localparam int TICK_W = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PSC_W-1:0]  PSC_MAX  = PSC_W'(PWM_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYCLES - 1);

  localparam logic [3:0] PAT_BRAKE = 4'b1111;
  localparam logic [3:0] PAT_COAST = 4'b0000;

  typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

  state_t             state, state_nxt;
  logic [3:0]         pat, pat_nxt;
  logic [3:0]         idle_pat, idle_pat_nxt;
  logic [PWM_W-1:0]   speed, speed_nxt;
  logic [DUR_W-1:0]   dur_cnt, dur_nxt;
  logic [PSC_W-1:0]   psc, psc_nxt;
  logic [PWM_W-1:0]   pwm_cnt, pwm_nxt;
  logic [TICK_W-1:0]  tick, tick_nxt;
  logic [DEAD_W-1:0]  dead_cnt, dead_nxt;
  logic [3:0]         motor_nxt;
  logic               busy_nxt, done_nxt;
  logic               accept, is_drive, restart;
  logic [3:0]         drive_pat;

  assign cmd.cmd_ready = (state != DEAD);

  always_comb begin
    state_nxt    = state;
    pat_nxt      = pat;
    idle_pat_nxt = idle_pat;
    speed_nxt    = speed;
    dur_nxt      = dur_cnt;
    psc_nxt      = psc;
    pwm_nxt      = pwm_cnt;
    tick_nxt     = tick;
    dead_nxt     = dead_cnt;
    done_nxt     = 1'b0;
    restart      = 1'b0;
    accept       = cmd.cmd_valid && cmd.cmd_ready;
    is_drive     = 1'b1;
    drive_pat    = PAT_COAST;

    case (cmd.cmd_dir)
      3'b000:  drive_pat = 4'b1001;
      3'b001:  drive_pat = 4'b0110;
      3'b100:  drive_pat = 4'b0101;
      3'b101:  drive_pat = 4'b1010;
      default: is_drive  = 1'b0;
    endcase

    case (state)
      RUN: begin
        if (psc == PSC_MAX) begin
          psc_nxt = '0;
          pwm_nxt = pwm_cnt + 1'b1;
        end else begin
          psc_nxt = psc + 1'b1;
        end
        if (tick == TICK_MAX) begin
          tick_nxt = '0;
          if (dur_cnt == DUR_W'(1)) begin
            dur_nxt      = '0;
            state_nxt    = IDLE;
            idle_pat_nxt = PAT_BRAKE;
            done_nxt     = 1'b1;
          end else if (dur_cnt != '0) begin
            dur_nxt = dur_cnt - 1'b1;
          end
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      DEAD: begin
        if (dead_cnt == DEAD_MAX) begin
          state_nxt = RUN;
          restart   = 1'b1;
        end else begin
          dead_nxt = dead_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    // An accepted command overrides whatever the expiry path decided this cycle.
    if (accept) begin
      done_nxt = 1'b0;
      if (cmd.cmd_dir == 3'b010 || cmd.cmd_dir == 3'b011) begin
        state_nxt    = IDLE;
        idle_pat_nxt = (cmd.cmd_dir == 3'b010) ? PAT_BRAKE : PAT_COAST;
      end else if (is_drive) begin
        speed_nxt = cmd.cmd_speed;
        dur_nxt   = cmd.cmd_dur;
        pat_nxt   = drive_pat;
        if (state == RUN && pat == drive_pat) begin
          state_nxt = RUN;
        end else if (state == RUN) begin
          state_nxt = DEAD;
          dead_nxt  = '0;
        end else begin
          state_nxt = RUN;
          restart   = 1'b1;
        end
      end else if (state == RUN) begin
        state_nxt = RUN;
        speed_nxt = cmd.cmd_speed;
        dur_nxt   = cmd.cmd_dur;
      end
    end

    if (restart) begin
      psc_nxt  = '0;
      pwm_nxt  = '0;
      tick_nxt = '0;
    end

    case (state_nxt)
      RUN:     motor_nxt = (pwm_nxt < speed_nxt) ? pat_nxt : PAT_COAST;
      DEAD:    motor_nxt = PAT_COAST;
      default: motor_nxt = idle_pat_nxt;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state    <= IDLE;
      pat      <= PAT_COAST;
      idle_pat <= PAT_BRAKE;
      speed    <= '0;
      dur_cnt  <= '0;
      psc      <= '0;
      pwm_cnt  <= '0;
      tick     <= '0;
      dead_cnt <= '0;
      motor    <= PAT_BRAKE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pat      <= pat_nxt;
      idle_pat <= idle_pat_nxt;
      speed    <= speed_nxt;
      dur_cnt  <= dur_nxt;
      psc      <= psc_nxt;
      pwm_cnt  <= pwm_nxt;
      tick     <= tick_nxt;
      dead_cnt <= dead_nxt;
      motor    <= motor_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl with small parameters (PWM_W=4, PWM_DIV=1, TICK_DIV=10, DEAD=5).
module tb_motor_drive_ctrl;
  logic       CLK100MHZ = 1'b0;
  logic       rst;
  logic [3:0] motor;
  logic       busy, done;
  int         checks   = 0;
  int         failures = 0;

  motor_drive_ctrl_if #(.PWM_W(4), .DUR_W(8)) cmd_if ();

  motor_drive_ctrl #(
    .PWM_W(4), .PWM_DIV(1), .TICK_DIV(10), .DUR_W(8), .DEAD_CYCLES(5)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .cmd      (cmd_if),
    .motor    (motor),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] dir, input logic [3:0] spd, input logic [7:0] dur);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = dir;
    cmd_if.cmd_speed = spd;
    cmd_if.cmd_dur   = dur;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 3'b000;
    cmd_if.cmd_speed = 4'd4;
    cmd_if.cmd_dur   = 8'd0;
    tick();
    tick();
    // Reset state, with a command offered during reset that must be ignored
    chk("rst_motor", motor, 4'b1111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_if.cmd_ready, 1'b1);
    cmd_if.cmd_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_motor", motor, 4'b1111);
    chk("idle_busy", busy, 1'b0);

    // Forward, speed 4, untimed: 4 on / 12 off, period 16
    send(3'b000, 4'd4, 8'd0);
    chk("fwd_busy", busy, 1'b1);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("fwd4_pwm_%0d", k), motor, ((k % 16) < 4) ? 4'b1001 : 4'b0000);
      tick();
    end

    send(3'b010, 4'd0, 8'd0);
    chk("brake_motor", motor, 4'b1111);
    chk("brake_busy", busy, 1'b0);
    chk("brake_done", done, 1'b0);

    // Forward, speed 15, three ticks: 30 cycles then brake and one done pulse
    send(3'b000, 4'd15, 8'd3);
    for (int k = 0; k < 30; k++) begin
      chk($sformatf("t3_motor_%0d", k), motor, ((k % 16) < 15) ? 4'b1001 : 4'b0000);
      chk($sformatf("t3_done_%0d", k), done, 1'b0);
      tick();
    end
    chk("t3_exp_motor", motor, 4'b1111);
    chk("t3_exp_done", done, 1'b1);
    chk("t3_exp_busy", busy, 1'b0);
    tick();
    chk("t3_done_drop", done, 1'b0);
    chk("t3_after_motor", motor, 4'b1111);

    // Forward then back: five coast cycles with ready low; held valid waits for RUN
    send(3'b000, 4'd8, 8'd0);
    tick();
    tick();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = 3'b001;
    tick();
    cmd_if.cmd_dir   = 3'b100;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("dead_motor_%0d", k), motor, 4'b0000);
      chk($sformatf("dead_ready_%0d", k), cmd_if.cmd_ready, 1'b0);
      chk($sformatf("dead_busy_%0d", k), busy, 1'b1);
      tick();
    end
    chk("back_motor", motor, 4'b0110);
    chk("back_ready", cmd_if.cmd_ready, 1'b1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("dead2_motor_%0d", k), motor, 4'b0000);
      chk($sformatf("dead2_ready_%0d", k), cmd_if.cmd_ready, 1'b0);
      tick();
    end
    chk("left_motor", motor, 4'b0101);

    // HOLD with speed 0 while turning left: constant coast but still running
    send(3'b110, 4'd0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("hold0_motor_%0d", k), motor, 4'b0000);
      chk($sformatf("hold0_busy_%0d", k), busy, 1'b1);
      tick();
    end
    send(3'b010, 4'd0, 8'd0);
    chk("hold_brake_motor", motor, 4'b1111);
    chk("hold_brake_done", done, 1'b0);
    chk("hold_brake_busy", busy, 1'b0);
    tick();
    chk("hold_brake_done2", done, 1'b0);

    // Two-tick run preempted by coast exactly at the expiry edge
    send(3'b000, 4'd4, 8'd2);
    for (int k = 1; k < 20; k++) begin
      chk($sformatf("t2_done_%0d", k), done, 1'b0);
      tick();
    end
    chk("t2_pre_busy", busy, 1'b1);
    send(3'b011, 4'd0, 8'd0);
    chk("t2_coast_motor", motor, 4'b0000);
    chk("t2_coast_done", done, 1'b0);
    chk("t2_coast_busy", busy, 1'b0);
    tick();
    chk("t2_coast_done2", done, 1'b0);

    // Reset in the middle of a coast gap
    send(3'b000, 4'd4, 8'd0);
    tick();
    send(3'b001, 4'd4, 8'd0);
    tick();
    chk("mid_dead_motor", motor, 4'b0000);
    chk("mid_dead_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("rstdead_motor", motor, 4'b1111);
    chk("rstdead_busy", busy, 1'b0);
    chk("rstdead_done", done, 1'b0);
    chk("rstdead_ready", cmd_if.cmd_ready, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("post_rst_motor_%0d", k), motor, 4'b1111);
      chk($sformatf("post_rst_busy_%0d", k), busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
